// File: rtl/regfile_wr_sched.sv
// Single regfile write-port scheduler: post-reset clear sequencer, then
// fixed-priority mux of pipeline writeback over a small debug write FIFO.
module regfile_wr_sched #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int REG_NUM   = 32,
  parameter int DBG_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wb_we,
  input  logic [ADDR_W-1:0]            wb_waddr,
  input  logic [DATA_W-1:0]            wb_wdata,
  input  logic                         dbg_valid,
  output logic                         dbg_ready,
  input  logic [ADDR_W-1:0]            dbg_waddr,
  input  logic [DATA_W-1:0]            dbg_wdata,
  output logic [$clog2(DBG_DEPTH):0]   dbg_level,
  output logic                         rf_we,
  output logic [ADDR_W-1:0]            rf_waddr,
  output logic [DATA_W-1:0]            rf_wdata,
  output logic                         init_busy,
  output logic                         err_wb_init
);
  localparam int PW = $clog2(DBG_DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              err;
  wr_t               mem [DBG_DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [LW-1:0]     level;
  wr_t               head;
  logic              empty, full, push, pop;

  assign head      = mem[rptr];
  assign empty     = (level == '0);
  assign full      = (level == LW'(DBG_DEPTH));
  // Ready ignores a same-cycle pop so a full FIFO never pushes, even while draining.
  assign dbg_ready = rst && !full;
  assign push      = dbg_valid && dbg_ready;
  assign pop       = (state == RUN) && !wb_we && !empty;

  assign init_busy   = (state == INIT);
  assign err_wb_init = err;
  assign dbg_level   = level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= INIT;
      clr_cnt <= '0;
      err     <= 1'b0;
    end else if (state == INIT) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == ADDR_W'(REG_NUM - 1)) state <= RUN;
      if (wb_we) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage has no reset; occupancy/pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{addr: dbg_waddr, data: dbg_wdata};
  end

  // Zero-latency write-port mux; rf_we is gated by reset so it drops immediately.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (rst) begin
      if (state == INIT) begin
        rf_we    = 1'b1;
        rf_waddr = clr_cnt;
      end else if (wb_we) begin
        rf_we    = 1'b1;
        rf_waddr = wb_waddr;
        rf_wdata = wb_wdata;
      end else if (!empty) begin
        rf_we    = 1'b1;
        rf_waddr = head.addr;
        rf_wdata = head.data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wr_sched.sv
// Randomized/directed bench for regfile_wr_sched against a queue-based model
// of the clear sequence, write priority and debug FIFO.
module tb_regfile_wr_sched;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int RN = 32;
  localparam int DD = 4;

  logic          clk, rst;
  logic          wb_we, dbg_valid, dbg_ready;
  logic [AW-1:0] wb_waddr, dbg_waddr, rf_waddr;
  logic [DW-1:0] wb_wdata, dbg_wdata, rf_wdata;
  logic [2:0]    dbg_level;
  logic          rf_we, init_busy, err_wb_init;

  regfile_wr_sched #(.ADDR_W(AW), .DATA_W(DW), .REG_NUM(RN), .DBG_DEPTH(DD)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
    .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata), .dbg_level(dbg_level),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .init_busy(init_busy), .err_wb_init(err_wb_init)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  // Model: clear writes issued so far, pending debug writes, sticky error.
  int   init_idx;
  ent_t q[$];
  logic err_m;
  int   vectors, miscompares;

  // Expected {we, waddr, wdata, busy, ready, level, err} for the current inputs.
  function automatic logic [43:0] expv();
    logic          we, busy;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (!rst) return {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 3'd0, 1'b0};
    busy = (init_idx < RN);
    we = 1'b0; a = '0; d = '0;
    if (busy) begin
      we = 1'b1; a = AW'(init_idx);
    end else if (wb_we) begin
      we = 1'b1; a = wb_waddr; d = wb_wdata;
    end else if (q.size() > 0) begin
      we = 1'b1; a = q[0].a; d = q[0].d;
    end
    return {we, a, d, busy, q.size() < DD, 3'(q.size()), err_m};
  endfunction

  task automatic adv();
    bit busy, full;
    if (!rst) begin
      init_idx = 0; q.delete(); err_m = 1'b0;
    end else begin
      busy = (init_idx < RN);
      full = (q.size() >= DD);
      if (busy && wb_we) err_m = 1'b1;
      if (!busy && !wb_we && q.size() > 0) void'(q.pop_front());
      if (dbg_valid && !full) q.push_back('{a: dbg_waddr, d: dbg_wdata});
      if (busy) init_idx++;
    end
  endtask

  task automatic tick();
    adv();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    wb_we = 0; wb_waddr = '0; wb_wdata = '0;
    dbg_valid = 0; dbg_waddr = '0; dbg_wdata = '0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [43:0] e, o;
    quiet();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #3;
      e = expv();
      o = {rf_we, rf_waddr, rf_wdata, init_busy, dbg_ready, dbg_level, err_wb_init};
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", c, o, e);
      end
      tick();
    end
    rst = 1'b1;
    for (int c = 0; c < RN + 2; c++) begin
      #3;
      e = expv();
      o = {rf_we, rf_waddr, rf_wdata, init_busy, dbg_ready, dbg_level, err_wb_init};
      if (!e[43]) begin e[42:6] = '0; o[42:6] = '0; end
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL clear_seq cyc=%0d got=%h exp=%h", c, o, e);
      end
      tick();
    end
  endtask

  task automatic test_wb_passthrough();
    logic [43:0] e, o;
    for (int c = 0; c < 3; c++) begin
      quiet();
      if (c == 0) begin wb_we = 1; wb_waddr = 5'd5; wb_wdata = 32'hDEADBEEF; end
      if (c == 1) begin wb_we = 1; wb_waddr = 5'd0; wb_wdata = $urandom; end
      #3;
      e = expv();
      o = {rf_we, rf_waddr, rf_wdata, init_busy, dbg_ready, dbg_level, err_wb_init};
      if (!e[43]) begin e[42:6] = '0; o[42:6] = '0; end
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL wb_pass cyc=%0d got=%h exp=%h", c, o, e);
      end
      tick();
    end
  endtask

  task automatic test_dbg_fill_in_init();
    logic [43:0] e, o;
    do_reset();
    for (int c = 0; c < RN + 6; c++) begin
      quiet();
      if (c < 5) begin
        dbg_valid = 1; dbg_waddr = AW'(c + 1); dbg_wdata = 32'(8'h11 * (c + 1));
      end
      #3;
      e = expv();
      o = {rf_we, rf_waddr, rf_wdata, init_busy, dbg_ready, dbg_level, err_wb_init};
      if (!e[43]) begin e[42:6] = '0; o[42:6] = '0; end
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL dbg_fill cyc=%0d got=%h exp=%h", c, o, e);
      end
      tick();
    end
  endtask

  task automatic test_wb_priority();
    logic [43:0] e, o;
    for (int c = 0; c < 6; c++) begin
      quiet();
      if (c < 3) begin wb_we = 1; wb_waddr = 5'd7; wb_wdata = 32'h5A; end
      if (c == 0) begin dbg_valid = 1; dbg_waddr = 5'd7; dbg_wdata = 32'hA5; end
      #3;
      e = expv();
      o = {rf_we, rf_waddr, rf_wdata, init_busy, dbg_ready, dbg_level, err_wb_init};
      if (!e[43]) begin e[42:6] = '0; o[42:6] = '0; end
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL wb_priority cyc=%0d got=%h exp=%h", c, o, e);
      end
      tick();
    end
  endtask

  task automatic test_wb_in_init();
    logic [43:0] e, o;
    do_reset();
    for (int c = 0; c < RN + 4; c++) begin
      quiet();
      if (c == 10) begin wb_we = 1; wb_waddr = 5'd3; wb_wdata = 32'hCAFEF00D; end
      #3;
      e = expv();
      o = {rf_we, rf_waddr, rf_wdata, init_busy, dbg_ready, dbg_level, err_wb_init};
      if (!e[43]) begin e[42:6] = '0; o[42:6] = '0; end
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL wb_in_init cyc=%0d got=%h exp=%h", c, o, e);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_init();
    logic [43:0] e, o;
    do_reset();
    for (int c = 0; c < 24; c++) begin
      quiet();
      if (c < 2) begin dbg_valid = 1; dbg_waddr = AW'(20 + c); dbg_wdata = $urandom; end
      if (c == 21) rst = 1'b1;
      #3;
      e = expv();
      o = {rf_we, rf_waddr, rf_wdata, init_busy, dbg_ready, dbg_level, err_wb_init};
      if (rst && !e[43]) begin e[42:6] = '0; o[42:6] = '0; end
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL mid_reset cyc=%0d got=%h exp=%h", c, o, e);
      end
      if (c == 17) begin
        rst = 1'b0;
        #1;
        e = expv();
        o = {rf_we, rf_waddr, rf_wdata, init_busy, dbg_ready, dbg_level, err_wb_init};
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("FAIL async_reset got=%h exp=%h", o, e);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [43:0] e, o;
    rst = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      rst       = ($urandom_range(0, 199) != 0);
      wb_we     = ($urandom_range(0, 2) == 0) || (c >= 600 && c < 620);
      wb_waddr  = AW'($urandom);
      wb_wdata  = $urandom;
      dbg_valid = $urandom_range(0, 1);
      dbg_waddr = AW'($urandom);
      dbg_wdata = $urandom;
      #3;
      e = expv();
      o = {rf_we, rf_waddr, rf_wdata, init_busy, dbg_ready, dbg_level, err_wb_init};
      if (rst && !e[43]) begin e[42:6] = '0; o[42:6] = '0; end
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c, o, e);
      end
      tick();
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    init_idx = 0; err_m = 1'b0;
    quiet();
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_wb_passthrough();
    test_dbg_fill_in_init();
    test_wb_priority();
    test_wb_in_init();
    test_reset_mid_init();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
